// File: rtl/buzzer_tone_pkg.sv
// -----------------------------------------------------------------------------
// buzzer_tone_pkg
// Purpose : Shared definitions for the buzzer tone generator: note codes,
//           octave codes, the middle-octave half-period table (in 100 MHz
//           clock cycles) and the tone FSM state type.
// Ports   : none (package)
// -----------------------------------------------------------------------------
package buzzer_tone_pkg;

    // Note codes delivered by the auto-play stage
    localparam logic [3:0] NOTE_REST     = 4'd0;
    localparam logic [3:0] NOTE_DO       = 4'd1;
    localparam logic [3:0] NOTE_RE       = 4'd2;
    localparam logic [3:0] NOTE_MI       = 4'd3;
    localparam logic [3:0] NOTE_FA       = 4'd4;
    localparam logic [3:0] NOTE_SOL      = 4'd5;
    localparam logic [3:0] NOTE_LA       = 4'd6;
    localparam logic [3:0] NOTE_TI       = 4'd7;
    localparam logic [3:0] NOTE_END_MARK = 4'b1111;

    // Octave codes; 2'b11 is an alias of the middle octave
    localparam logic [1:0] OCT_LOW     = 2'b00;
    localparam logic [1:0] OCT_MID     = 2'b01;
    localparam logic [1:0] OCT_HIGH    = 2'b10;
    localparam logic [1:0] OCT_MID_ALT = 2'b11;

    // Middle-octave half periods in clk cycles
    localparam int         TABLE_W = 19;
    localparam logic [18:0] HP_DO  = 19'd191110;
    localparam logic [18:0] HP_RE  = 19'd170265;
    localparam logic [18:0] HP_MI  = 19'd151685;
    localparam logic [18:0] HP_FA  = 19'd143172;
    localparam logic [18:0] HP_SOL = 19'd127551;
    localparam logic [18:0] HP_LA  = 19'd113636;
    localparam logic [18:0] HP_TI  = 19'd101239;

    typedef enum logic [1:0] {
        ST_SILENT = 2'd0,
        ST_GAP    = 2'd1,
        ST_TONE   = 2'd2
    } state_t;

    // Table lookup; non-note codes return 0 (never used while sounding)
    function automatic logic [18:0] mid_half_period(input logic [3:0] note);
        case (note)
            NOTE_DO:  mid_half_period = HP_DO;
            NOTE_RE:  mid_half_period = HP_RE;
            NOTE_MI:  mid_half_period = HP_MI;
            NOTE_FA:  mid_half_period = HP_FA;
            NOTE_SOL: mid_half_period = HP_SOL;
            NOTE_LA:  mid_half_period = HP_LA;
            NOTE_TI:  mid_half_period = HP_TI;
            default:  mid_half_period = '0;
        endcase
    endfunction

    function automatic logic is_note_code(input logic [3:0] note);
        return (note >= NOTE_DO) && (note <= NOTE_TI);
    endfunction

endpackage

// File: rtl/note_period_lut.sv
// -----------------------------------------------------------------------------
// note_period_lut
// Purpose : Combinational half-period lookup. Low octave doubles the middle
//           value, high octave halves it (truncated).
// Ports   : i_note        [3:0]      note code
//           i_octave      [1:0]      octave code
//           o_half_period [HP_W-1:0] half period in clk cycles
// -----------------------------------------------------------------------------
module note_period_lut
    import buzzer_tone_pkg::*;
#(
    parameter int HP_W = 19
) (
    input  logic [3:0]      i_note,
    input  logic [1:0]      i_octave,
    output logic [HP_W-1:0] o_half_period
);

    // One extra bit so the low-octave shift never loses the MSB
    logic [TABLE_W:0] w_mid;
    logic [TABLE_W:0] w_scaled;

    always_comb begin
        w_mid = {1'b0, mid_half_period(i_note)};
        case (i_octave)
            OCT_LOW:  w_scaled = w_mid << 1;
            OCT_HIGH: w_scaled = w_mid >> 1;
            default:  w_scaled = w_mid;
        endcase
    end

    assign o_half_period = HP_W'(w_scaled);

endmodule

// File: rtl/buzzer_tone.sv
// -----------------------------------------------------------------------------
// buzzer_tone
// Purpose : Square-wave buzzer driver. Every change of {note, octave} inserts
//           a silent articulation gap of GAP_CYCLES clocks, then plays the
//           note as a square wave starting from phase 0.
// Ports   : clk          system clock (100 MHz)
//           reset        synchronous, active-high
//           enable       1 = sound permitted, 0 = forced silence
//           note_in[3:0] 0 rest, 1..7 do..ti, 15 end marker, 8..14 rest
//           octave_in[1:0] 00 low, 01 middle, 10 high, 11 middle
//           buzzer_out   registered square wave
//           tone_active  registered, high while a tone is sounding
// -----------------------------------------------------------------------------
module buzzer_tone
    import buzzer_tone_pkg::*;
#(
    parameter int GAP_CYCLES = 1_000_000,
    parameter int HP_W       = 19
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic [3:0] note_in,
    input  logic [1:0] octave_in,
    output logic       buzzer_out,
    output logic       tone_active
);

    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    // GAP_CYCLES of 0 or 1 both give a single-cycle gap
    localparam logic [GAP_W-1:0] GAP_LAST =
        (GAP_CYCLES > 1) ? GAP_W'(GAP_CYCLES - 1) : '0;

    state_t           r_state;
    logic [3:0]       r_cur_note;
    logic [1:0]       r_cur_oct;
    logic [HP_W-1:0]  r_hp_cnt;
    logic [GAP_W-1:0] r_gap_cnt;
    logic             r_buzzer;
    logic             r_tone;

    logic             w_change;
    logic             w_play_in;
    logic [HP_W-1:0]  w_half_period;
    logic [HP_W-1:0]  w_hp_last;

    assign w_change  = {note_in, octave_in} != {r_cur_note, r_cur_oct};
    assign w_play_in = enable && is_note_code(note_in);

    // Period follows the stored note; in TONE without a change it equals the input
    note_period_lut #(
        .HP_W(HP_W)
    ) u_note_period_lut (
        .i_note       (r_cur_note),
        .i_octave     (r_cur_oct),
        .o_half_period(w_half_period)
    );

    assign w_hp_last = w_half_period - HP_W'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_SILENT;
            r_cur_note <= NOTE_REST;
            r_cur_oct  <= OCT_MID;
            r_hp_cnt   <= '0;
            r_gap_cnt  <= '0;
            r_buzzer   <= 1'b0;
            r_tone     <= 1'b0;
        end else begin
            if (w_change) begin
                r_cur_note <= note_in;
                r_cur_oct  <= octave_in;
            end

            case (r_state)
                ST_SILENT: begin
                    // Covers both a change to a playable note and enable
                    // rising on an unchanged playable note: without a change
                    // the input equals the stored note.
                    if (w_play_in) begin
                        r_state   <= ST_GAP;
                        r_gap_cnt <= '0;
                    end
                    r_hp_cnt <= '0;
                    r_buzzer <= 1'b0;
                    r_tone   <= 1'b0;
                end

                ST_GAP: begin
                    // Non-playable wins over a simultaneous change
                    if (!w_play_in) begin
                        r_state   <= ST_SILENT;
                        r_gap_cnt <= '0;
                    end else if (w_change) begin
                        r_gap_cnt <= '0;
                    end else if (r_gap_cnt == GAP_LAST) begin
                        r_state   <= ST_TONE;
                        r_gap_cnt <= '0;
                        r_tone    <= 1'b1;
                    end else begin
                        r_gap_cnt <= r_gap_cnt + GAP_W'(1);
                    end
                    r_hp_cnt <= '0;
                    r_buzzer <= 1'b0;
                end

                ST_TONE: begin
                    if (!w_play_in) begin
                        r_state  <= ST_SILENT;
                        r_hp_cnt <= '0;
                        r_buzzer <= 1'b0;
                        r_tone   <= 1'b0;
                    end else if (w_change) begin
                        r_state   <= ST_GAP;
                        r_gap_cnt <= '0;
                        r_hp_cnt  <= '0;
                        r_buzzer  <= 1'b0;
                        r_tone    <= 1'b0;
                    end else if (r_hp_cnt == w_hp_last) begin
                        r_hp_cnt <= '0;
                        r_buzzer <= ~r_buzzer;
                    end else begin
                        r_hp_cnt <= r_hp_cnt + HP_W'(1);
                    end
                end

                default: begin
                    r_state   <= ST_SILENT;
                    r_hp_cnt  <= '0;
                    r_gap_cnt <= '0;
                    r_buzzer  <= 1'b0;
                    r_tone    <= 1'b0;
                end
            endcase
        end
    end

    assign buzzer_out  = r_buzzer;
    assign tone_active = r_tone;

endmodule

// File: tb/tb_buzzer_tone.sv
// -----------------------------------------------------------------------------
// tb_buzzer_tone
// Scoreboard bench: stimulus pushes the expected {state, tone_active,
// buzzer_out} transitions with their hand-computed cycle; a monitor pops and
// compares on every observed output change. GAP_CYCLES = 4.
// -----------------------------------------------------------------------------
module tb_buzzer_tone;
    import buzzer_tone_pkg::*;

    localparam int GAP  = 4;
    localparam int HP_W = 19;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic [3:0] note_in;
    logic [1:0] octave_in;
    logic       buzzer_out;
    logic       tone_active;

    logic [3:0]      lut_note;
    logic [1:0]      lut_oct;
    logic [HP_W-1:0] lut_hp;

    int cyc     = 0;
    int n_tests = 0;
    int n_fail  = 0;
    int b       = 0;

    typedef struct {
        int         cyc;
        logic [1:0] st;
        logic       tone;
        logic       buzz;
    } ev_t;

    ev_t sb[$];

    // Hand-entered middle-octave half periods
    int mid_tab [1:7] = '{191110, 170265, 151685, 143172, 127551, 113636, 101239};

    buzzer_tone #(
        .GAP_CYCLES(GAP),
        .HP_W      (HP_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .note_in    (note_in),
        .octave_in  (octave_in),
        .buzzer_out (buzzer_out),
        .tone_active(tone_active)
    );

    note_period_lut #(
        .HP_W(HP_W)
    ) u_lut_chk (
        .i_note       (lut_note),
        .i_octave     (lut_oct),
        .o_half_period(lut_hp)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got no end of test by cycle %0d, required finish", cyc);
        $fatal(1, "timeout");
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic r, input logic en, input logic [3:0] n, input logic [1:0] o);
        reset     = r;
        enable    = en;
        note_in   = n;
        octave_in = o;
        b         = cyc;
    endtask

    task automatic expect_ev(input int c, input logic [1:0] st, input logic tone, input logic buzz);
        ev_t e;
        e.cyc  = c;
        e.st   = st;
        e.tone = tone;
        e.buzz = buzz;
        sb.push_back(e);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    task automatic monitor();
        logic [3:0] prev;
        logic [3:0] cur;
        ev_t        e;
        prev = {dut.r_state, tone_active, buzzer_out};
        forever begin
            @(negedge clk);
            cur = {dut.r_state, tone_active, buzzer_out};
            if (cur !== prev) begin
                n_tests++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_event: got cyc=%0d state/tone/buzz=%b, required no change",
                             cyc, cur);
                end else begin
                    e = sb.pop_front();
                    if (e.cyc != cyc || cur !== {e.st, e.tone, e.buzz}) begin
                        n_fail++;
                        $display("FAIL output_event: got cyc=%0d state/tone/buzz=%b, required cyc=%0d state/tone/buzz=%b",
                                 cyc, cur, e.cyc, {e.st, e.tone, e.buzz});
                    end
                end
                prev = cur;
            end
        end
    endtask

    // Gap then tone for a playable change driven at cycle b
    task automatic expect_gap_tone();
        expect_ev(b + 1, ST_GAP, 1'b0, 1'b0);
        expect_ev(b + 1 + GAP, ST_TONE, 1'b1, 1'b0);
    endtask

    initial begin
        int exp_hp;

        // Half-period table, all notes and octave codes
        for (int n = 1; n <= 7; n++) begin
            for (int o = 0; o < 4; o++) begin
                lut_note = 4'(n);
                lut_oct  = 2'(o);
                #1;
                exp_hp = (o == 0) ? mid_tab[n] * 2 : (o == 2) ? mid_tab[n] / 2 : mid_tab[n];
                check($sformatf("lut_note%0d_oct%0d", n, o), 32'(lut_hp), exp_hp);
            end
        end

        // Reset with inputs active: reset must win
        drive(1'b1, 1'b1, 4'd6, 2'b01);
        step(3);
        check("rst_state", 32'(dut.r_state), 32'(ST_SILENT));
        check("rst_buzzer", 32'(buzzer_out), 0);
        check("rst_tone", 32'(tone_active), 0);
        check("rst_hp_cnt", 32'(dut.r_hp_cnt), 0);
        check("rst_gap_cnt", 32'(dut.r_gap_cnt), 0);
        check("rst_cur_note", 32'(dut.r_cur_note), 0);
        check("rst_cur_oct", 32'(dut.r_cur_oct), 1);

        fork
            monitor();
        join_none

        // Note 6 middle after release: 4-cycle gap then tone
        drive(1'b0, 1'b1, 4'd6, 2'b01);
        expect_gap_tone();
        step(8);
        check("la_mid_hp", 32'(dut.w_half_period), 113636);
        check("tone_hp_cnt_running", 32'(dut.r_hp_cnt), 3);

        // End marker during tone
        drive(1'b0, 1'b1, 4'd15, 2'b01);
        expect_ev(b + 1, ST_SILENT, 1'b0, 1'b0);
        step(3);

        // Note 5 high, then rest code 9 during tone
        drive(1'b0, 1'b1, 4'd5, 2'b10);
        expect_gap_tone();
        step(8);
        drive(1'b0, 1'b1, 4'd9, 2'b10);
        expect_ev(b + 1, ST_SILENT, 1'b0, 1'b0);
        step(3);

        // Enable drop mid-tone, restore with unchanged note
        drive(1'b0, 1'b1, 4'd2, 2'b01);
        expect_gap_tone();
        step(8);
        drive(1'b0, 1'b0, 4'd2, 2'b01);
        expect_ev(b + 1, ST_SILENT, 1'b0, 1'b0);
        step(3);
        drive(1'b0, 1'b1, 4'd2, 2'b01);
        expect_gap_tone();
        step(8);

        // Enable drop mid-gap, restore
        drive(1'b0, 1'b1, 4'd4, 2'b01);
        expect_ev(b + 1, ST_GAP, 1'b0, 1'b0);
        step(2);
        drive(1'b0, 1'b0, 4'd4, 2'b01);
        expect_ev(b + 1, ST_SILENT, 1'b0, 1'b0);
        step(3);
        drive(1'b0, 1'b1, 4'd4, 2'b01);
        expect_gap_tone();
        step(8);

        // 3 -> 5 -> 3 -> 5 -> 3 every 2 cycles: gap keeps restarting
        drive(1'b0, 1'b1, 4'd3, 2'b01);
        expect_ev(b + 1, ST_GAP, 1'b0, 1'b0);
        step(2);
        check("gap_cnt_counting", 32'(dut.r_gap_cnt), 1);
        drive(1'b0, 1'b1, 4'd5, 2'b01);
        step(2);
        drive(1'b0, 1'b1, 4'd3, 2'b01);
        step(2);
        drive(1'b0, 1'b1, 4'd5, 2'b01);
        step(2);
        check("gap_cnt_restarted", 32'(dut.r_gap_cnt), 1);
        drive(1'b0, 1'b1, 4'd3, 2'b01);
        expect_ev(b + 1 + GAP, ST_TONE, 1'b1, 1'b0);
        step(8);

        // Enable fall together with a note change: silence wins
        drive(1'b0, 1'b0, 4'd6, 2'b01);
        expect_ev(b + 1, ST_SILENT, 1'b0, 1'b0);
        step(3);
        check("cur_note_loaded_silent", 32'(dut.r_cur_note), 6);
        drive(1'b0, 1'b1, 4'd6, 2'b01);
        expect_gap_tone();
        step(8);

        // Repeated identical code: tone continues, no gap
        drive(1'b0, 1'b1, 4'd6, 2'b01);
        step(4);
        check("repeat_no_gap_hp_cnt", 32'(dut.r_hp_cnt), 7);

        // Note 1 low, then high octave
        drive(1'b0, 1'b1, 4'd1, 2'b00);
        expect_gap_tone();
        step(8);
        check("do_low_hp", 32'(dut.w_half_period), 382220);
        drive(1'b0, 1'b1, 4'd1, 2'b10);
        expect_gap_tone();
        step(8);
        check("do_high_hp", 32'(dut.w_half_period), 95555);

        // Note 7 high: first rising edge 50619 cycles after entering tone
        drive(1'b0, 1'b1, 4'd7, 2'b10);
        expect_gap_tone();
        expect_ev(b + 1 + GAP + 50619, ST_TONE, 1'b1, 1'b1);
        step(1 + GAP + 50619 + 1);
        check("hp_cnt_after_toggle", 32'(dut.r_hp_cnt), 1);
        check("buzzer_high", 32'(buzzer_out), 1);

        // Reset during tone with buzzer high, inputs still active
        drive(1'b1, 1'b1, 4'd7, 2'b10);
        expect_ev(b + 1, ST_SILENT, 1'b0, 1'b0);
        step(1);
        check("midtone_rst_hp_cnt", 32'(dut.r_hp_cnt), 0);
        check("midtone_rst_gap_cnt", 32'(dut.r_gap_cnt), 0);
        check("midtone_rst_cur_note", 32'(dut.r_cur_note), 0);
        check("midtone_rst_cur_oct", 32'(dut.r_cur_oct), 1);
        step(2);

        // Release with the same playable input: seen as a change
        drive(1'b0, 1'b1, 4'd7, 2'b10);
        expect_gap_tone();
        step(8);

        step(2);
        check("scoreboard_drained", 32'(sb.size()), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
